aes_key_sched_ctrl: RTL and testbench

//  Sequencer that wraps aes_key_gen and performs the full AES-128 key expansion.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_round_key_store.sv | 43 ++++
 rtl/aes_key_sched_ctrl.sv | 135 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM encoding and small helpers.
package aes_pkg;

    localparam int AES_NR       = 10;
    localparam int AES_BLK_W    = 128;
    localparam int AES_RK_IDX_W = 4;
    localparam int AES_NUM_RK   = AES_NR + 1;

    localparam logic [1:0] KS_IDLE  = 2'd0;
    localparam logic [1:0] KS_ISSUE = 2'd1;
    localparam logic [1:0] KS_WAIT  = 2'd2;
    localparam logic [1:0] KS_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = KS_IDLE,
        ST_ISSUE = KS_ISSUE,
        ST_WAIT  = KS_WAIT,
        ST_DONE  = KS_DONE
    } ks_state_e;

    // True when idx addresses one of the stored round keys (0..AES_NR).
    function automatic logic rk_idx_valid(input logic [AES_RK_IDX_W-1:0] idx);
        return idx <= AES_RK_IDX_W'(AES_NR);
    endfunction

endpackage

// File: rtl/aes_round_key_store.sv
// Round-key register file: one write port, one registered read port.
// Reset zeroizes every entry and the read register; indices above the
// last round key read back as zero and are never written.
module aes_round_key_store
    import aes_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [AES_RK_IDX_W-1:0] wr_idx_i,
    input  logic [AES_BLK_W-1:0]    wr_data_i,
    input  logic [AES_RK_IDX_W-1:0] rd_idx_i,
    output logic [AES_BLK_W-1:0]    rd_data_o
);

    logic [AES_BLK_W-1:0] rk_q [0:AES_NR];
    logic [AES_BLK_W-1:0] rd_data_q;

    // Storage array: zeroize on reset, otherwise accept in-range writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= AES_NR; i++) begin
                rk_q[i] <= '0;
            end
        end else if (we_i && rk_idx_valid(wr_idx_i)) begin
            rk_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Registered read; a same-edge write is seen on the following read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rk_idx_valid(rd_idx_i)) begin
            rd_data_q <= rk_q[rd_idx_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer. Takes a cipher key over valid/ready,
// steps an external aes_key_gen through rounds 0..9 feeding each result
// back in, and keeps all 11 round keys in a store the cipher core reads
// by index.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | no key loaded; ready for a cipher key
//  ISSUE | one-cycle enable pulse to aes_key_gen for round rnd
//  WAIT  | KEY_GEN_LAT cycles for aes_key_gen; capture on the last one
//  DONE  | all round keys valid; ready to accept a new key
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_GEN_LAT = 1,
    parameter int NR          = AES_NR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_key_valid,
    output logic                    o_key_ready,
    input  logic [AES_BLK_W-1:0]    i_key,
    output logic                    o_en_key_gen,
    output logic [3:0]              o_round_num,
    output logic [AES_BLK_W-1:0]    o_pre_rnd_key,
    input  logic [AES_BLK_W-1:0]    i_next_rnd_key,
    input  logic [AES_RK_IDX_W-1:0] i_rd_idx,
    output logic [AES_BLK_W-1:0]    o_rd_key,
    output logic                    o_keys_ready,
    output logic                    o_busy
);

    localparam int WAIT_W = 3;

    ks_state_e              state_q, state_d;
    logic [3:0]             rnd_q, rnd_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                   keys_ready_q, keys_ready_d;
    // Copy of rk[rnd]: the store's only read port belongs to the cipher
    // core, so the key fed back to aes_key_gen is tracked here.
    logic [AES_BLK_W-1:0]   pre_key_q, pre_key_d;

    logic                    idle_or_done;
    logic                    accept;
    logic                    st_we;
    logic [AES_RK_IDX_W-1:0] st_wr_idx;
    logic [AES_BLK_W-1:0]    st_wr_data;

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign o_key_ready  = idle_or_done && !rst;
    assign accept       = i_key_valid && o_key_ready;

    // State, round counter, wait counter and feedback key registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rnd_q        <= '0;
            wait_cnt_q   <= '0;
            keys_ready_q <= 1'b0;
            pre_key_q    <= '0;
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            wait_cnt_q   <= wait_cnt_d;
            keys_ready_q <= keys_ready_d;
            pre_key_q    <= pre_key_d;
        end
    end

    // Next-state, store write control and key-gen handshake outputs.
    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        wait_cnt_d   = wait_cnt_q;
        keys_ready_d = keys_ready_q;
        pre_key_d    = pre_key_q;
        st_we        = 1'b0;
        st_wr_idx    = rnd_q + 4'd1;
        st_wr_data   = i_next_rnd_key;
        o_en_key_gen = 1'b0;
        o_busy       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    st_we        = 1'b1;
                    st_wr_idx    = '0;
                    st_wr_data   = i_key;
                    pre_key_d    = i_key;
                    rnd_d        = '0;
                    keys_ready_d = 1'b0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_busy       = 1'b1;
                o_en_key_gen = 1'b1;
                wait_cnt_d   = WAIT_W'(KEY_GEN_LAT);
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                o_busy = 1'b1;
                if (wait_cnt_q == WAIT_W'(1)) begin
                    st_we     = 1'b1;
                    pre_key_d = i_next_rnd_key;
                    if (rnd_q == 4'(NR - 1)) begin
                        keys_ready_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        rnd_d   = rnd_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_round_num   = rnd_q;
    assign o_pre_rnd_key = pre_key_q;
    assign o_keys_ready  = keys_ready_q;

    aes_round_key_store u_key_store (
        .clk       (clk),
        .rst       (rst),
        .we_i      (st_we),
        .wr_idx_i  (st_wr_idx),
        .wr_data_i (st_wr_data),
        .rd_idx_i  (i_rd_idx),
        .rd_data_o (o_rd_key)
    );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl paired with a one-cycle aes_key_gen stand-in.
// Expected round keys come from a word-level FIPS-197 expansion.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_key_valid;
    logic         o_key_ready;
    logic [127:0] i_key;
    logic         o_en_key_gen;
    logic [3:0]   o_round_num;
    logic [127:0] o_pre_rnd_key;
    logic [127:0] i_next_rnd_key;
    logic [3:0]   i_rd_idx;
    logic [127:0] o_rd_key;
    logic         o_keys_ready;
    logic         o_busy;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]   sbox [0:255];
    logic [127:0] ref_rk [0:10];
    logic [127:0] kg_q = '0;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.KEY_GEN_LAT(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_key_valid    (i_key_valid),
        .o_key_ready    (o_key_ready),
        .i_key          (i_key),
        .o_en_key_gen   (o_en_key_gen),
        .o_round_num    (o_round_num),
        .o_pre_rnd_key  (o_pre_rnd_key),
        .i_next_rnd_key (i_next_rnd_key),
        .i_rd_idx       (i_rd_idx),
        .o_rd_key       (o_rd_key),
        .o_keys_ready   (o_keys_ready),
        .o_busy         (o_busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] x;
        x = 8'h01;
        for (int i = 1; i < n; i++) x = xtime(x);
        return x;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    // One round of expansion, as the external aes_key_gen computes it.
    function automatic logic [127:0] kg_round(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] t, n0, n1, n2, n3;
        t  = subw({k[23:0], k[31:24]}) ^ {rcon(int'(r) + 1), 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always @(posedge clk) begin
        if (o_en_key_gen) kg_q <= kg_round(o_pre_rnd_key, o_round_num);
    end
    assign i_next_rnd_key = kg_q;

    // Word-oriented expansion of the whole schedule.
    task automatic build_ref(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon(i / 4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] exp_rd(input int idx, input logic zero);
        if (zero || idx > 10) return '0;
        return ref_rk[idx];
    endfunction

    // Load a key and follow the expansion to completion; optionally hold
    // valid with a competing key the whole time.
    task automatic do_expand(input logic [127:0] key, input logic bp, input logic [127:0] bp_key);
        int k;
        int pulses;
        chk("key_ready_idle", 128'(o_key_ready), 128'(1));
        build_ref(key);
        i_key       = key;
        i_key_valid = 1'b1;
        @(negedge clk);
        if (bp) i_key = bp_key;
        else    i_key_valid = 1'b0;
        k      = 0;
        pulses = 0;
        chk("keys_ready_drop", 128'(o_keys_ready), 128'(0));
        while (!o_keys_ready && k < 100) begin
            chk("busy", 128'(o_busy), 128'(1));
            if (bp) chk("key_ready_bp", 128'(o_key_ready), 128'(0));
            if (o_en_key_gen) begin
                chk("round_num", 128'(o_round_num), 128'(pulses));
                if (pulses < 11) chk("pre_rnd_key", o_pre_rnd_key, ref_rk[pulses]);
                pulses++;
            end
            @(negedge clk);
            k++;
        end
        i_key_valid = 1'b0;
        chk("latency", 128'(k), 128'(20));
        chk("en_pulses", 128'(pulses), 128'(10));
        chk("busy_done", 128'(o_busy), 128'(0));
        chk("key_ready_done", 128'(o_key_ready), 128'(1));
    endtask

    task automatic read_all(input logic zero);
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) chk(zero ? "rd_zero" : "rd_stream", o_rd_key, exp_rd(i - 1, zero));
            if (i <= 15) i_rd_idx = 4'(i);
            @(negedge clk);
        end
    endtask

    task automatic rd_one(input int idx, output logic [127:0] data);
        i_rd_idx = 4'(idx);
        @(negedge clk);
        data = o_rd_key;
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] rkey;
        int           prev;
        int           idx;

        build_sbox();
        rst         = 1'b1;
        i_key_valid = 1'b0;
        i_key       = '0;
        i_rd_idx    = '0;
        repeat (2) @(negedge clk);
        chk("rst_key_ready", 128'(o_key_ready), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_key_ready_idle", 128'(o_key_ready), 128'(1));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_keys_ready", 128'(o_keys_ready), 128'(0));
        chk("rst_en", 128'(o_en_key_gen), 128'(0));
        chk("rst_round", 128'(o_round_num), 128'(0));
        chk("rst_pre_key", o_pre_rnd_key, 128'(0));
        chk("rst_rd_key", o_rd_key, 128'(0));

        // FIPS-197 A.1 with a competing key held on the input.
        do_expand(KEY_A1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
        read_all(1'b0);
        rd_one(0, d);
        chk("a1_idx0", d, KEY_A1);
        rd_one(1, d);
        chk("a1_idx1", d, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_one(10, d);
        chk("a1_idx10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("keys_ready_hold", 128'(o_keys_ready), 128'(1));

        // Rekey from DONE with the all-zero key.
        do_expand('0, 1'b0, '0);
        rd_one(10, d);
        chk("zero_idx10", d, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        read_all(1'b0);

        // Random keys, random backpressure, random read order.
        for (int n = 0; n < 4; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            do_expand(rkey, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
            prev = -1;
            for (int r = 0; r < 20; r++) begin
                if (prev >= 0) chk("rd_rand", o_rd_key, exp_rd(prev, 1'b0));
                idx      = int'($urandom_range(0, 15));
                i_rd_idx = 4'(idx);
                prev     = idx;
                @(negedge clk);
            end
            chk("rd_rand", o_rd_key, exp_rd(prev, 1'b0));
        end

        // Reset during expansion: sampled at the 7th edge after accept.
        build_ref(KEY_A1);
        i_key       = KEY_A1;
        i_key_valid = 1'b1;
        @(negedge clk);
        i_key_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_key_ready_rst", 128'(o_key_ready), 128'(0));
        chk("abort_busy", 128'(o_busy), 128'(0));
        chk("abort_keys_ready", 128'(o_keys_ready), 128'(0));
        chk("abort_en", 128'(o_en_key_gen), 128'(0));
        rst = 1'b0;
        read_all(1'b1);
        chk("abort_keys_ready_after", 128'(o_keys_ready), 128'(0));

        do_expand(KEY_A1, 1'b0, '0);
        read_all(1'b0);
        rd_one(10, d);
        chk("rerun_idx10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
